// File: rtl/mc_datapath_mul.sv
`default_nettype none
// ============================================================================
// Module  : mc_datapath_mul
// Brief   : Multicycle ARM datapath with an iterative shift-add multiplier
//           exposed as a fourth Result source. Define MUL_LONG_EN to also
//           produce the upper half of the double-width product on MulOutHi.
// Revision: 1.0 - initial release
// ============================================================================
module mc_datapath_mul #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 4,
  parameter int PC_INC = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] Instr,
  input  logic [1:0]       RegSrc,
  input  logic             RegWrite,
  input  logic [1:0]       ImmSrc,
  input  logic             ALUSrcA,
  input  logic [1:0]       ALUSrcB,
  input  logic [1:0]       ALUControl,
  input  logic             AdrSrc,
  input  logic             PCWrite,
  input  logic             IRWrite,
  input  logic [1:0]       ResultSrc,
  input  logic             MulStart,
  output logic [WIDTH-1:0] Adr,
  output logic [WIDTH-1:0] WriteData,
  input  logic [WIDTH-1:0] ReadData,
  output logic [3:0]       ALUFlags,
  output logic [WIDTH-1:0] ALUResult,
  output logic             MulBusy,
  output logic             MulDone
`ifdef MUL_LONG_EN
  ,
  output logic [WIDTH-1:0] MulOutHi
`endif
);

  localparam int c_nregs = 2 ** REG_AW;
  localparam logic [REG_AW-1:0] c_top = '1;
`ifdef MUL_LONG_EN
  localparam int c_acc_w = 2 * WIDTH;
`else
  localparam int c_acc_w = WIDTH;
`endif
  localparam int c_cnt_w = $clog2(WIDTH) + 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [WIDTH-1:0] r_pc, r_instr, r_data, r_a, r_b, r_aluout, r_mulout;
  logic [WIDTH-1:0] r_rf [c_nregs];
  logic [REG_AW-1:0] w_ra1, w_ra2, w_wa;
  logic [WIDTH-1:0] w_rd1, w_rd2, w_result, w_extimm, w_srca, w_srcb, w_bop;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_alures;
  logic             w_c, w_v;

  logic [1:0]         r_state, w_state_next;
  logic [c_acc_w-1:0] r_mcand, r_acc, w_acc_next;
  logic [WIDTH-1:0]   r_mplier;
  logic [c_cnt_w-1:0] r_count;

  logic w_unused;
  assign w_unused = ^r_instr[WIDTH-1:24];

  assign Instr     = r_instr;
  assign WriteData = r_b;
  assign ALUResult = w_alures;
  assign Adr       = AdrSrc ? w_result : r_pc;

  // Register file; the top index aliases the current Result instead of storage.
  assign w_ra1 = RegSrc[0] ? c_top : REG_AW'(r_instr[19:16]);
  assign w_ra2 = RegSrc[1] ? REG_AW'(r_instr[15:12]) : REG_AW'(r_instr[3:0]);
  assign w_wa  = REG_AW'(r_instr[15:12]);
  assign w_rd1 = (w_ra1 == c_top) ? w_result : r_rf[w_ra1];
  assign w_rd2 = (w_ra2 == c_top) ? w_result : r_rf[w_ra2];

  always_ff @(posedge clk) begin
    if (RegWrite) r_rf[w_wa] <= w_result;
  end

  always_comb begin
    w_extimm = '0;
    case (ImmSrc)
      2'b00:   w_extimm = WIDTH'(r_instr[7:0]);
      2'b01:   w_extimm = WIDTH'(r_instr[11:0]);
      2'b10:   w_extimm = {{(WIDTH-26){r_instr[23]}}, r_instr[23:0], 2'b00};
      default: w_extimm = '0;
    endcase
  end

  assign w_srca = ALUSrcA ? r_pc : r_a;

  always_comb begin
    w_srcb = '0;
    case (ALUSrcB)
      2'b00:   w_srcb = r_b;
      2'b01:   w_srcb = w_extimm;
      2'b10:   w_srcb = WIDTH'(PC_INC);
      default: w_srcb = '0;
    endcase
  end

  // Subtract is a + ~b + 1, so carry-out directly means "no borrow".
  assign w_bop = ALUControl[0] ? ~w_srcb : w_srcb;
  assign w_sum = {1'b0, w_srca} + {1'b0, w_bop} + {{WIDTH{1'b0}}, ALUControl[0]};

  always_comb begin
    w_alures = w_sum[WIDTH-1:0];
    w_c      = 1'b0;
    w_v      = 1'b0;
    case (ALUControl)
      2'b10:   w_alures = w_srca & w_srcb;
      2'b11:   w_alures = w_srca | w_srcb;
      default: begin
        w_c = w_sum[WIDTH];
        w_v = (w_srca[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != w_srca[WIDTH-1]);
      end
    endcase
  end

  assign ALUFlags = {w_alures[WIDTH-1], (w_alures == '0), w_c, w_v};

  always_comb begin
    w_result = r_aluout;
    case (ResultSrc)
      2'b00:   w_result = r_aluout;
      2'b01:   w_result = r_data;
      2'b10:   w_result = w_alures;
      default: w_result = r_mulout;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= '0;
      r_instr  <= '0;
      r_data   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
    end else begin
      r_data   <= ReadData;
      r_a      <= w_rd1;
      r_b      <= w_rd2;
      r_aluout <= w_alures;
      if (PCWrite) r_pc    <= w_result;
      if (IRWrite) r_instr <= ReadData;
    end
  end

  // Multiplier control: state register, next-state logic, outputs.
  always_ff @(posedge clk) begin
    if (reset) r_state <= c_st_idle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (MulStart) w_state_next = c_st_run;
      c_st_run:  if (r_count == c_last) w_state_next = c_st_done;
      c_st_done: w_state_next = c_st_idle;
      default:   w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    MulBusy = (r_state == c_st_run);
    MulDone = (r_state == c_st_done);
  end

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_mulout <= '0;
`ifdef MUL_LONG_EN
      MulOutHi <= '0;
`endif
    end else begin
      case (r_state)
        c_st_idle: begin
          if (MulStart) begin
            r_mcand  <= c_acc_w'(r_a);
            r_mplier <= r_b;
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        c_st_run: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
          if (r_count == c_last) begin
            r_mulout <= w_acc_next[WIDTH-1:0];
`ifdef MUL_LONG_EN
            MulOutHi <= w_acc_next[c_acc_w-1 -: WIDTH];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath_mul.sv
`default_nettype none
// ============================================================================
// Module  : tb_mc_datapath_mul
// Brief   : Scoreboard bench for mc_datapath_mul (directed vectors).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mc_datapath_mul;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] Instr, Adr, WriteData, ReadData, ALUResult;
  logic [1:0]   RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;
  logic         RegWrite, ALUSrcA, AdrSrc, PCWrite, IRWrite, MulStart;
  logic [3:0]   ALUFlags;
  logic         MulBusy, MulDone;
`ifdef MUL_LONG_EN
  logic [W-1:0] MulOutHi;
`endif

  mc_datapath_mul #(.WIDTH(W), .REG_AW(4), .PC_INC(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .RegSrc(RegSrc), .RegWrite(RegWrite),
    .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .AdrSrc(AdrSrc), .PCWrite(PCWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .MulStart(MulStart), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
    .ALUFlags(ALUFlags), .ALUResult(ALUResult), .MulBusy(MulBusy), .MulDone(MulDone)
`ifdef MUL_LONG_EN
    , .MulOutHi(MulOutHi)
`endif
  );

  always #5 clk = ~clk;

  localparam int S_ADR = 0, S_INSTR = 1, S_WDATA = 2, S_ALU = 3, S_FLAGS = 4, S_BUSY = 5, S_DONE = 6;

  typedef struct { int sel; logic [W-1:0] exp; string name; } dp_t;
  typedef struct { logic [W-1:0] lo; logic [W-1:0] hi; string name; } mul_t;
  dp_t  dq[$];
  mul_t mq[$];
  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;

  function automatic void chk(string name, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endfunction

  function automatic logic [W-1:0] observe(int sel);
    case (sel)
      S_ADR:   return Adr;
      S_INSTR: return Instr;
      S_WDATA: return WriteData;
      S_ALU:   return ALUResult;
      S_FLAGS: return {28'b0, ALUFlags};
      S_BUSY:  return {31'b0, MulBusy};
      default: return {31'b0, MulDone};
    endcase
  endfunction

  // Monitor: drains datapath expectations each cycle, pops a product on every MulDone.
  always @(negedge clk) begin
    dp_t  e;
    mul_t m;
    while (dq.size() > 0) begin
      e = dq.pop_front();
      chk(e.name, observe(e.sel), e.exp);
    end
    if (reset) busy_cnt = 0;
    else if (MulBusy) busy_cnt++;
    if (MulDone) begin
      if (mq.size() == 0) begin
        chk("unexpected_muldone", {31'b0, MulDone}, '0);
      end else begin
        m = mq.pop_front();
        chk({m.name, "_lo"}, Adr, m.lo);
        chk({m.name, "_busy_cycles"}, busy_cnt, W);
`ifdef MUL_LONG_EN
        chk({m.name, "_hi"}, MulOutHi, m.hi);
`endif
      end
      busy_cnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_dp(int sel, logic [W-1:0] exp, string name);
    dp_t e;
    e.sel = sel; e.exp = exp; e.name = name;
    dq.push_back(e);
  endtask

  task automatic set_instr(logic [W-1:0] w);
    ReadData = w; IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
  endtask

  task automatic write_reg(logic [W-1:0] v);
    ReadData = v;
    tick();
    ResultSrc = 2'b01; RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0;
  endtask

  // Leaves A = r1 = a, B = r2 = b with Instr = 0x00010002 (Rn=1, Rm=2, imm8=2).
  task automatic load_ab(logic [W-1:0] a, logic [W-1:0] b);
    RegSrc = 2'b00;
    set_instr(32'h0000_1000); write_reg(a);
    set_instr(32'h0000_2000); write_reg(b);
    set_instr(32'h0001_0002);
    tick();
  endtask

  task automatic mul_run(logic [W-1:0] a, logic [W-1:0] b, string name, bit poke_run, bit poke_done);
    mul_t m;
    logic [2*W-1:0] p;
    bit done;
    load_ab(a, b);
    p = (2*W)'(a) * (2*W)'(b);
    m.lo = p[W-1:0]; m.hi = p[2*W-1:W]; m.name = name;
    mq.push_back(m);
    AdrSrc = 1'b1; ResultSrc = 2'b11;
    MulStart = 1'b1;
    tick();
    MulStart = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (poke_run && i == 10) MulStart = 1'b1;
      tick();
      MulStart = 1'b0;
      if (MulDone) begin
        done = 1'b1;
        if (poke_done) begin
          MulStart = 1'b1;
          tick();
          MulStart = 1'b0;
        end
        break;
      end
    end
    if (!done) chk({name, "_timeout"}, {31'b0, done}, 1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ReadData = '0; RegSrc = '0; RegWrite = 0; ImmSrc = '0; ALUSrcA = 0;
    ALUSrcB = '0; ALUControl = '0; AdrSrc = 0; PCWrite = 0; IRWrite = 0; ResultSrc = '0;
    MulStart = 0;
    tick(); tick();
    expect_dp(S_ADR, 0, "reset_adr");
    expect_dp(S_INSTR, 0, "reset_instr");
    expect_dp(S_WDATA, 0, "reset_writedata");
    expect_dp(S_BUSY, 0, "reset_mulbusy");
    expect_dp(S_DONE, 0, "reset_muldone");
    tick();
    reset = 1'b0;

    // Fetch: PC + 4 through the ALU, instruction latched from memory.
    ReadData = 32'hE281_1005; IRWrite = 1; ALUSrcA = 1; ALUSrcB = 2'b10;
    ALUControl = 2'b00; ResultSrc = 2'b10; PCWrite = 1; AdrSrc = 0;
    expect_dp(S_ALU, 32'h4, "fetch_pc_plus_inc");
    tick();
    IRWrite = 0; PCWrite = 0;
    expect_dp(S_INSTR, 32'hE281_1005, "fetch_instr");
    expect_dp(S_ADR, 32'h4, "fetch_pc");
    tick();

    load_ab(32'h7FFF_FFFF, 32'h1);
    ALUSrcA = 0; ALUSrcB = 2'b00; ALUControl = 2'b00;
    expect_dp(S_ALU, 32'h8000_0000, "add_ovf_result");
    expect_dp(S_FLAGS, 4'b1001, "add_ovf_flags");
    expect_dp(S_WDATA, 32'h1, "writedata_b");
    tick();
    ALUControl = 2'b10;
    expect_dp(S_ALU, 32'h1, "and_result");
    expect_dp(S_FLAGS, 4'b0000, "and_flags");
    tick();
    ALUControl = 2'b11;
    expect_dp(S_ALU, 32'h7FFF_FFFF, "orr_result");
    tick();
    ALUControl = 2'b00; ALUSrcB = 2'b01; ImmSrc = 2'b00;
    expect_dp(S_ALU, 32'h8000_0001, "ext_zext8");
    expect_dp(S_FLAGS, 4'b1001, "ext_zext8_flags");
    tick();
    ImmSrc = 2'b10;
    expect_dp(S_ALU, 32'h8004_0007, "ext_branch");
    tick();
    ALUSrcB = 2'b11;
    expect_dp(S_ALU, 32'h7FFF_FFFF, "srcb_zero");
    tick();

    load_ab(32'h5, 32'h5);
    ALUSrcB = 2'b00; ALUControl = 2'b01;
    expect_dp(S_ALU, 32'h0, "sub_equal_result");
    expect_dp(S_FLAGS, 4'b0110, "sub_equal_flags");
    tick();
    load_ab(32'h3, 32'h5);
    expect_dp(S_ALU, 32'hFFFF_FFFE, "sub_borrow_result");
    expect_dp(S_FLAGS, 4'b1000, "sub_borrow_flags");
    tick();

    mul_run(32'd7, 32'd6, "mul_7x6", 0, 0);
    mul_run(32'd3, 32'd5, "mul_restart_ignored", 1, 1);
    repeat (40) tick();
    mul_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max", 0, 0);
    mul_run(32'h1234_5678, 32'h9ABC_DEF0, "mul_mixed", 0, 0);

    // Abort mid-run: result cleared and no completion pulse afterwards.
    load_ab(32'd9, 32'd9);
    AdrSrc = 1'b1; ResultSrc = 2'b11;
    MulStart = 1'b1;
    tick();
    MulStart = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_dp(S_ADR, 0, "abort_mulout_cleared");
    expect_dp(S_BUSY, 0, "abort_idle");
    repeat (40) tick();

    chk("scoreboard_drained", mq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
